// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU issue stage: opcodes, instruction field
// positions and a single decode helper used by the issue logic.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;
  localparam int IMM_LSB = 20;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_I,
    CLS_ILLEGAL
  } instr_cls_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } slot_t;

  typedef struct packed {
    instr_cls_e  cls;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.opcode = instr[OPC_LSB +: 7];
    d.rd     = instr[RD_LSB +: 5];
    d.funct3 = instr[F3_LSB +: 3];
    d.rs1    = instr[RS1_LSB +: 5];
    d.rs2    = instr[RS2_LSB +: 5];
    d.funct7 = instr[F7_LSB +: 7];
    d.imm    = {{20{instr[31]}}, instr[IMM_LSB +: 12]};
    if (d.opcode == OPC_OP)
      d.cls = CLS_R;
    else if (d.opcode == OPC_OP_IMM)
      d.cls = CLS_I;
    else
      d.cls = CLS_ILLEGAL;
    return d;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32-entry register file: two combinational operand reads, one debug read and
// one synchronous write port; x0 reads as zero and is never written.
module regfile_2r1w #(
  parameter int XLEN         = 32,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem [32];

  always_ff @(posedge clk) begin
    if (rst && CLEAR_ON_RST) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= '0;
      end
    end else if (we && waddr != 5'd0) begin
      mem[waddr] <= wdata;
    end
  end

  // Entry 0 may hold garbage when reset clearing is disabled, so mask it here.
  assign rdata1   = (raddr1 == 5'd0)   ? '0 : mem[raddr1];
  assign rdata2   = (raddr2 == 5'd0)   ? '0 : mem[raddr2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/operand stage in front of the 2-cycle RV32I ALU: decodes OP/OP-IMM,
// reads operands with E2 forwarding, stalls on E1 hazards and writes back c.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter bit RF_CLEAR_ON_RST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] c,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  dec_t  dec;
  logic  is_r;
  logic  legal;
  logic  stall;
  logic  issue;
  logic  wb_en;

  slot_t e1_reg, e1_next;
  slot_t e2_reg;
  logic  illegal_reg;

  logic [1:0][4:0]      src_addr;
  logic [1:0]           src_used;
  logic [1:0]           hit_e1;
  logic [1:0]           hit_e2;
  logic [1:0][XLEN-1:0] rf_rdata;
  logic [1:0][XLEN-1:0] src_data;

  assign dec   = decode(instr);
  assign is_r  = (dec.cls == CLS_R);
  assign legal = (dec.cls != CLS_ILLEGAL);

  // Illegal words never read sources, so they never stall.
  assign src_addr[0] = dec.rs1;
  assign src_addr[1] = dec.rs2;
  assign src_used[0] = legal;
  assign src_used[1] = is_r;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign hit_e1[gi] = src_used[gi] && (src_addr[gi] != 5'd0) &&
                          e1_reg.valid && (e1_reg.rd == src_addr[gi]);
      assign hit_e2[gi] = src_used[gi] && (src_addr[gi] != 5'd0) &&
                          e2_reg.valid && (e2_reg.rd == src_addr[gi]);
      assign src_data[gi] = hit_e2[gi] ? c : rf_rdata[gi];
    end
  endgenerate

  assign stall    = |hit_e1;
  assign in_ready = ~rst & ~stall;
  assign issue    = in_valid & in_ready;

  // Illegal words are consumed without presenting anything to the ALU.
  always_comb begin
    opcode = '0;
    funct3 = '0;
    funct7 = '0;
    a      = '0;
    b      = '0;
    if (issue && legal) begin
      opcode = dec.opcode;
      funct3 = dec.funct3;
      if (is_r || dec.funct3 == F3_SLL || dec.funct3 == F3_SR)
        funct7 = dec.funct7;
      a = src_data[0];
      b = is_r ? src_data[1] : dec.imm;
    end
  end

  always_comb begin
    e1_next       = '0;
    e1_next.valid = issue & legal;
    e1_next.rd    = dec.rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e1_reg      <= '0;
      e2_reg      <= '0;
      illegal_reg <= 1'b0;
    end else begin
      e2_reg      <= e1_reg;
      e1_reg      <= e1_next;
      illegal_reg <= issue & ~legal;
    end
  end

  // A reset cycle squashes whatever is sitting in E2.
  assign wb_en        = e2_reg.valid && (e2_reg.rd != 5'd0) && !rst;
  assign retire_valid = e2_reg.valid & ~rst;
  assign retire_rd    = e2_reg.rd;
  assign illegal      = illegal_reg;

  regfile_2r1w #(
    .XLEN        (XLEN),
    .CLEAR_ON_RST(RF_CLEAR_ON_RST)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .raddr1  (src_addr[0]),
    .rdata1  (rf_rdata[0]),
    .raddr2  (src_addr[1]),
    .rdata2  (rf_rdata[1]),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .we      (wb_en),
    .waddr   (e2_reg.rd),
    .wdata   (c)
  );

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Upstream issue/operand stage for the pipelined RV32I ALU block (2-cycle latency: operands presented in cycle t, result on c in cycle t+2).
- Accepts raw 32-bit instructions over a valid/ready handshake.
- Decodes R-type (0110011) and I-type ALU (0010011) instructions.
- Reads a 32x32 register file and drives opcode/funct3/funct7/a/b to the ALU.
- Tracks in-flight destinations, forwards or stalls on hazards, and writes c back into the register file.

Parameters:
XLEN, 32, datapath/register width (only 32 supported)
RF_CLEAR_ON_RST, 1, 1 = zero all registers on reset; 0 = register file contents untouched by reset

Ports:
clk  input  1  clock
rst  input  1  reset
in_valid  input  1  instruction offered
in_ready  output  1  instruction accepted this cycle when in_valid & in_ready
instr  input  32  RV32I instruction word
opcode  output  7  to ALU, instr[6:0] on issue, else 0
funct3  output  3  to ALU
funct7  output  7  to ALU
a  output  32  to ALU, rs1 operand
b  output  32  to ALU, rs2 operand or sign-extended imm
c  input  32  ALU result, registered output of ALU block
retire_valid  output  1  E2 slot valid this cycle (result on c being written back)
retire_rd  output  5  destination of retiring instruction
illegal  output  1  registered 1-cycle pulse: an accepted instr had an unsupported opcode
dbg_addr  input  5  debug register-file read address
dbg_data  output  32  rf[dbg_addr], combinational; 0 for address 0

Behaviour:
- Interface: clock and reset are clk and rst. One clock. Reset is synchronous and active-high.
- Reset: in_ready=0 while rst=1. E1/E2 valid cleared. illegal=0. retire_valid=0. Register file zeroed if RF_CLEAR_ON_RST. Reset mid-operation squashes in-flight instructions: no writeback occurs.
- Pipeline tracking:
  - E1 = {valid, rd} of the instruction issued last cycle.
  - E2 = {valid, rd} of the instruction issued two cycles ago; its result is on c now.
  - Each edge: E2<=E1; E1<={issue & legal, rd}.
- Writeback: if E2.valid & E2.rd!=0, rf[E2.rd]<=c at this edge. An instruction issued at t+3 sees the value through the register file.
- Hazards:
  - rs1 is used by both types; rs2 by R-type only.
  - A used source equal to E1.rd (E1.valid, rd!=0) => stall: in_ready=0, nothing issued, ALU ports driven 0.
  - Else a used source equal to E2.rd (E2.valid, rd!=0) => operand taken from c (forward).
  - Else operand taken from rf.
  - Source x0 always reads 0 and never forwards.
- Issue: issue = in_valid & in_ready.
  - R-type: a=rs1, b=rs2, funct7=instr[31:25].
  - I-type: a=rs1, b=sext(instr[31:20]). funct7=instr[31:25] when funct3 is 001 or 101 (shifts, so SRAI works); otherwise funct7=0.
  - funct3=instr[14:12].
  - When not issuing, all ALU ports are driven 0.
- Illegal: any other opcode is accepted (no hazard check), does not enter E1, and sets illegal=1 for the next cycle.
- in_ready = ~rst & ~stall. It depends combinationally on instr, never on downstream state.
- Throughput: one instruction/cycle absent distance-1 dependencies. A distance-1 dependency costs exactly one bubble.
- No result is ever written to x0.

Decomposition:
- Shared package alu_pkg: OPC_OP=7'b0110011, OPC_OP_IMM=7'b0010011, field-slice positions, XLEN.
- One natural sub-module: regfile_2r1w (2 combinational read ports plus debug read, 1 sync write port, x0 hardwired 0, sync reset clear).

Test Plan:
- Reset: hold rst 2 cycles -> in_ready=0 during reset, then 1. retire_valid=0, illegal=0, dbg_data=0 for all 32 addresses.
- Single op: issue 0x00500093 (addi x1,x0,5) at t -> opcode=0x13, a=0, b=5 at t. retire_valid=1, retire_rd=1 at t+2 (drive c=5). dbg x1=5 at t+3.
- Distance-1 stall: 0x00500093 then 0x00308113 (addi x2,x1,3) -> in_ready=0 for one cycle. Second op issued at t+2 with a=5 forwarded from c. x2=8.
- Distance-2 forward: 0x00500093, 0x00000313, 0x00108233 (add x4,x1,x1) -> no stall. Third op: a=b=5 from c, funct7=0. x4=10.
- x0 handling: 0x00900013 (addi x0,x0,9) then 0x000003B3 (add x7,x0,x0) -> no stall, x0 stays 0, x7=0.
- Illegal and reset mid-flight:
  - 0x00000073 -> accepted, illegal=1 next cycle, no retire.
  - Issue 0x00500093, assert rst the next cycle -> no writeback, x1=0.
